ge_p1p1_conv_seq: RTL and testbench
===================================

# ge_p1p1_conv_seq

Sequencer that converts an Ed25519 point from completed (P1P1) coordinates to projective P2 or extended P3 coordinates with a single shared field multiplier. It latches the four input limb vectors, issues the required products one at a time (or back-to-back when pipelining is compiled in) over a request/grant/response interface, and collects the results into registered outputs. It sits between the point-add/double datapath and the shared `fe_mul` resource, replacing a four-multiplier combinational conversion.

## Interface
- `FE_W`, default 320: field-element width; 10 signed 32-bit limbs.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a conversion; sampled only in IDLE.
- `mode`  in  1  0 = P1P1→P2 (3 products), 1 = P1P1→P3 (4 products); latched with `start`.
- `p_X`, `p_Y`, `p_Z`, `p_T`  in  FE_W each  P1P1 input coordinates; latched with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse; `r_*` valid from this cycle until the next accepted `start`.
- `r_X`, `r_Y`, `r_Z`, `r_T`  out  FE_W each  registered results.
- `mul_req`  out  1  multiplier request valid.
- `mul_a`, `mul_b`  out  FE_W each  operands; stable while `mul_req` is high and not granted.
- `mul_gnt`  in  1  request accepted in this cycle when `mul_req` is high.
- `mul_rsp_valid`  in  1  product valid; responses return in grant order, at least 1 cycle after grant.
- `mul_rsp`  in  FE_W  product.

## Operation
- Product table, fixed order: idx0 X·T→r_X; idx1 Y·Z→r_Y; idx2 Z·T→r_Z; idx3 X·Y→r_T (P3 only). N = 3 (P2) or 4 (P3).
- States: IDLE → ISSUE → WAIT → (ISSUE | DONE) → IDLE.
- IDLE: `start` latches the inputs and `mode`, clears `idx` to 0, and enters ISSUE. In P2 mode `r_T` is cleared to 0 at this point.
- ISSUE: `mul_req`=1 with the operands for `idx`. Stays in ISSUE until `mul_gnt`, then enters WAIT.
- WAIT: `mul_req`=0. When `mul_rsp_valid` is high, `mul_rsp` is written to the result for `idx`. If `idx` = N−1 the block enters DONE; otherwise `idx` increments and the block re-enters ISSUE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` is ignored while `busy`.
- `mul_rsp_valid` is ignored in IDLE/ISSUE/DONE when no product is outstanding.
- Results are stored bit-exact. The block does no arithmetic or reduction of its own.
- `rst` mid-operation: aborts immediately, returns to IDLE, and drops `mul_req`. Any in-flight response after reset is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `mul_req`=0, `mul_a`=`mul_b`=0, all `r_*`=0, state IDLE.
- The `start` cycle is cycle 0. The first `mul_req` is asserted in cycle 1.
- With immediate grant and multiplier latency L (grant to `mul_rsp_valid`), product n (1-based) returns in cycle n(L+1). `done` is asserted in cycle N(L+1)+1.
- Each grant stall adds one cycle.
- `busy` falls in the cycle after `done`. A new `start` is accepted in the cycle after `done`.

## Configuration
- `GE_CONV_PIPE_EN` defined:
  - ISSUE advances `idx` on every grant and keeps `mul_req` high until all N products are granted.
  - A separate response counter routes products in order. DONE is entered on the Nth response.
  - Responses may arrive while issue continues.
  - With immediate grant, `done` is asserted in cycle N+L+1.
- `GE_CONV_PIPE_EN` undefined: strictly one outstanding product, as described under Operation.

## Structure
- Shared package `ed25519_pkg`:
  - `FE_W`
  - `fe_t` (logic signed [FE_W-1:0])
  - `conv_mode_e` {CONV_P2, CONV_P3}
  - product-index constants
  - state enum
- One sub-module, `ge_conv_opsel`: combinational operand mux (idx → `mul_a`, `mul_b`) and destination decode. The FSM, counters and result registers stay in the top level.

## Test plan
The bench uses a multiplier model with fixed latency L=3 that returns the low FE_W bits of a·b.
- P3, immediate grant. Stimulus: X=2, Y=3, Z=5, T=7. Response: r_X=14, r_Y=15, r_Z=35, r_T=6; `done` in cycle 17, single pulse.
- P2, same inputs. Response: r_X=14, r_Y=15, r_Z=35, r_T=0; `done` in cycle 13; exactly 3 grants.
- Grant withheld 4 cycles on idx1. Response: `mul_a`/`mul_b` stay stable at Y/Z throughout the stall; `done` is delayed by exactly 4 cycles.
- `start` pulsed while busy, and a spurious `mul_rsp_valid` in ISSUE. Both are ignored; results are unchanged.
- `rst` asserted in WAIT of idx2. Response: all outputs 0 immediately. The late response is ignored. A following P3 `start` completes correctly.
- With `GE_CONV_PIPE_EN`, P3, L=3. Response: `mul_req` high in cycles 1–4; `done` in cycle 8; results as in the first scenario.

Source files
------------

// File: rtl/ed25519_pkg.sv
// Shared types and constants for the Ed25519 point-conversion slice.
// Optional feature macro used by ge_p1p1_conv_seq: GE_CONV_PIPE_EN.
package ed25519_pkg;

  // Field element: 10 signed 32-bit limbs.
  localparam int unsigned FE_W = 320;

  typedef logic signed [FE_W-1:0] fe_t;

  typedef enum logic {
    CONV_P2 = 1'b0,
    CONV_P3 = 1'b1
  } conv_mode_e;

  // Product table, issued in this fixed order.
  localparam logic [1:0] IDX_X_T = 2'd0;  // X*T -> r_X
  localparam logic [1:0] IDX_Y_Z = 2'd1;  // Y*Z -> r_Y
  localparam logic [1:0] IDX_Z_T = 2'd2;  // Z*T -> r_Z
  localparam logic [1:0] IDX_X_Y = 2'd3;  // X*Y -> r_T (P3 only)

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } conv_state_e;

  // Index of the final product for the given mode.
  function automatic logic [1:0] conv_last_idx(conv_mode_e m);
    return (m == CONV_P3) ? IDX_X_Y : IDX_Z_T;
  endfunction

endpackage

// File: rtl/ge_p1p1_conv_seq_if.sv
// Request/grant/response bus to the shared field multiplier.
interface ge_p1p1_conv_seq_if;
  import ed25519_pkg::*;

  logic mul_req;
  fe_t  mul_a;
  fe_t  mul_b;
  logic mul_gnt;
  logic mul_rsp_valid;
  fe_t  mul_rsp;

  modport master (
    output mul_req, mul_a, mul_b,
    input  mul_gnt, mul_rsp_valid, mul_rsp
  );

  modport slave (
    input  mul_req, mul_a, mul_b,
    output mul_gnt, mul_rsp_valid, mul_rsp
  );

endinterface

// File: rtl/ge_conv_opsel.sv
// Operand mux for the product being issued and destination decode for the
// product being returned.
module ge_conv_opsel
  import ed25519_pkg::*;
(
  input  logic [1:0] issue_idx,
  input  logic [1:0] rsp_idx,
  input  fe_t        x,
  input  fe_t        y,
  input  fe_t        z,
  input  fe_t        t,
  output fe_t        a,
  output fe_t        b,
  output logic [3:0] dest
);

  // Select operand pair for the issuing product.
  always_comb begin
    a = '0;
    b = '0;
    unique case (issue_idx)
      IDX_X_T: begin a = x; b = t; end
      IDX_Y_Z: begin a = y; b = z; end
      IDX_Z_T: begin a = z; b = t; end
      IDX_X_Y: begin a = x; b = y; end
      default: begin a = '0; b = '0; end
    endcase
  end

  // One-hot result register select: bit0 r_X, bit1 r_Y, bit2 r_Z, bit3 r_T.
  always_comb begin
    dest = 4'b0000;
    unique case (rsp_idx)
      IDX_X_T: dest = 4'b0001;
      IDX_Y_Z: dest = 4'b0010;
      IDX_Z_T: dest = 4'b0100;
      IDX_X_Y: dest = 4'b1000;
      default: dest = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ge_p1p1_conv_seq.sv
// P1P1 -> P2/P3 conversion sequencer driving one shared field multiplier.
// Build option: define GE_CONV_PIPE_EN to issue products back-to-back with
// several outstanding; otherwise exactly one product is outstanding at a time.
module ge_p1p1_conv_seq
  import ed25519_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mode,
  input  fe_t  p_X,
  input  fe_t  p_Y,
  input  fe_t  p_Z,
  input  fe_t  p_T,
  output logic busy,
  output logic done,
  output fe_t  r_X,
  output fe_t  r_Y,
  output fe_t  r_Z,
  output fe_t  r_T,
  ge_p1p1_conv_seq_if.master mul
);

  conv_state_e state_q;
  conv_mode_e  mode_q;
  fe_t         x_q, y_q, z_q, t_q;
  fe_t         rx_q, ry_q, rz_q, rt_q;
  fe_t         op_a, op_b;
  logic [1:0]  idx_q;
  logic [1:0]  last_idx;
  logic [1:0]  rsp_idx;
  logic [3:0]  dest;
  logic        req_q, busy_q, done_q;
  logic        rsp_take, rsp_last;
`ifdef GE_CONV_PIPE_EN
  logic [2:0]  gnt_cnt_q;
  logic [2:0]  rsp_cnt_q;
`endif

  assign last_idx = conv_last_idx(mode_q);

  // Decide whether the incoming response belongs to us and which slot it fills.
  always_comb begin
`ifdef GE_CONV_PIPE_EN
    rsp_idx  = rsp_cnt_q[1:0];
    rsp_take = mul.mul_rsp_valid && (state_q == StIssue || state_q == StWait) &&
               (gnt_cnt_q != rsp_cnt_q);
`else
    rsp_idx  = idx_q;
    rsp_take = mul.mul_rsp_valid && (state_q == StWait);
`endif
    rsp_last = rsp_take && (rsp_idx == last_idx);
  end

  ge_conv_opsel u_opsel (
    .issue_idx (idx_q),
    .rsp_idx   (rsp_idx),
    .x         (x_q),
    .y         (y_q),
    .z         (z_q),
    .t         (t_q),
    .a         (op_a),
    .b         (op_b),
    .dest      (dest)
  );

  // Control FSM: input latch, issue index, request and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= CONV_P2;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      t_q     <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GE_CONV_PIPE_EN
      gnt_cnt_q <= '0;
      rsp_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_q  <= conv_mode_e'(mode);
            x_q     <= p_X;
            y_q     <= p_Y;
            z_q     <= p_Z;
            t_q     <= p_T;
            idx_q   <= '0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StIssue;
`ifdef GE_CONV_PIPE_EN
            gnt_cnt_q <= '0;
            rsp_cnt_q <= '0;
`endif
          end
        end
        StIssue: begin
`ifdef GE_CONV_PIPE_EN
          if (mul.mul_gnt) begin
            gnt_cnt_q <= gnt_cnt_q + 3'd1;
            if (idx_q == last_idx) begin
              req_q   <= 1'b0;
              state_q <= StWait;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
`else
          if (mul.mul_gnt) begin
            req_q   <= 1'b0;
            state_q <= StWait;
          end
`endif
        end
        StWait: begin
`ifdef GE_CONV_PIPE_EN
          if (rsp_last) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
`else
          if (rsp_last) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (rsp_take) begin
            idx_q   <= idx_q + 2'd1;
            req_q   <= 1'b1;
            state_q <= StIssue;
          end
`endif
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
`ifdef GE_CONV_PIPE_EN
      // Responses can land while later products are still being issued.
      if (rsp_take) rsp_cnt_q <= rsp_cnt_q + 3'd1;
`endif
    end
  end

  // Result registers: written bit-exact from the multiplier response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q <= '0;
      ry_q <= '0;
      rz_q <= '0;
      rt_q <= '0;
    end else begin
      if (state_q == StIdle && start && conv_mode_e'(mode) == CONV_P2) rt_q <= '0;
      if (rsp_take) begin
        if (dest[0]) rx_q <= mul.mul_rsp;
        if (dest[1]) ry_q <= mul.mul_rsp;
        if (dest[2]) rz_q <= mul.mul_rsp;
        if (dest[3]) rt_q <= mul.mul_rsp;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign r_X         = rx_q;
  assign r_Y         = ry_q;
  assign r_Z         = rz_q;
  assign r_T         = rt_q;
  assign mul.mul_req = req_q;
  assign mul.mul_a   = op_a;
  assign mul.mul_b   = op_b;

endmodule

// File: tb/tb_ge_p1p1_conv_seq.sv
// Directed bench for ge_p1p1_conv_seq with a fixed-latency (L=3) multiplier model.
// Expectations follow GE_CONV_PIPE_EN when it is defined for the build.
module tb_ge_p1p1_conv_seq;
  import ed25519_pkg::*;

  localparam int L = 3;
`ifdef GE_CONV_PIPE_EN
  localparam int DONE_P3 = 8;
  localparam int DONE_P2 = 7;
  localparam int DONE_STALL = 12;
  localparam int STALL_FROM = 2;
  localparam int RST_CYC = 3;
  localparam logic [31:0] REQ_P3 = 32'h0000_001E;
`else
  localparam int DONE_P3 = 17;
  localparam int DONE_P2 = 13;
  localparam int DONE_STALL = 21;
  localparam int STALL_FROM = 5;
  localparam int RST_CYC = 10;
  localparam logic [31:0] REQ_P3 = 32'h0000_2222;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mode = 1'b0;
  fe_t  p_X = '0, p_Y = '0, p_Z = '0, p_T = '0;
  logic busy, done;
  fe_t  r_X, r_Y, r_Z, r_T;

  logic stall = 1'b0;
  logic inj_valid = 1'b0;
  fe_t  inj_data = '0;

  int tests = 0;
  int fails = 0;

  ge_p1p1_conv_seq_if mul_bus ();

  ge_p1p1_conv_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .p_X   (p_X),
    .p_Y   (p_Y),
    .p_Z   (p_Z),
    .p_T   (p_T),
    .busy  (busy),
    .done  (done),
    .r_X   (r_X),
    .r_Y   (r_Y),
    .r_Z   (r_Z),
    .r_T   (r_T),
    .mul   (mul_bus)
  );

  always #5 clk = ~clk;

  // Multiplier model: grant when not stalled, product appears L cycles after grant.
  logic v1, v2, v3;
  fe_t  d1, d2, d3;
  assign mul_bus.mul_gnt       = mul_bus.mul_req && !stall;
  assign mul_bus.mul_rsp_valid = v3 | inj_valid;
  assign mul_bus.mul_rsp       = inj_valid ? inj_data : d3;

  always @(posedge clk) begin
    v1 <= mul_bus.mul_req && mul_bus.mul_gnt;
    d1 <= mul_bus.mul_a * mul_bus.mul_b;
    v2 <= v1;
    d2 <= d1;
    v3 <= v2;
    d3 <= d2;
  end

  // One conversion; cycle 0 is the start cycle, returns sampled in the done cycle.
  task automatic run_conv(input logic m, input fe_t x, input fe_t y, input fe_t z,
                          input fe_t t, input int stall_from, input int stall_len,
                          input bit disturb, output int done_cyc, output int grants,
                          output bit stable_ok, output logic [31:0] req_hist);
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_entry: busy=%b done=%b, required busy=0 done=0", busy, done);
    end
    p_X = x; p_Y = y; p_Z = z; p_T = t; mode = m; start = 1'b1;
    done_cyc = -1; grants = 0; stable_ok = 1'b1; req_hist = '0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stall = (n >= stall_from) && (n < stall_from + stall_len);
      inj_valid = disturb && (n == 1);
      inj_data = fe_t'(777);
      if (disturb && n == 3) begin
        start = 1'b1; p_X = fe_t'(99); mode = ~m;
      end
      if (disturb && n == 4) begin
        p_X = x; mode = m;
      end
      #1;
      if (mul_bus.mul_req && n < 32) req_hist[n] = 1'b1;
      if (mul_bus.mul_req && mul_bus.mul_gnt) grants++;
      if (stall && (!mul_bus.mul_req || mul_bus.mul_a !== y || mul_bus.mul_b !== z))
        stable_ok = 1'b0;
      if (done === 1'b1) begin
        done_cyc = n;
        break;
      end
    end
    stall = 1'b0; inj_valid = 1'b0; start = 1'b0;
    tests++;
    if (done_cyc < 0) begin
      fails++;
      $display("FAIL done_timeout: done not seen within 80 cycles");
    end
  endtask

  task automatic check_res(input string name, input fe_t ex, input fe_t ey, input fe_t ez,
                           input fe_t et);
    tests++;
    if (r_X !== ex || r_Y !== ey || r_Z !== ez || r_T !== et) begin
      fails++;
      $display("FAIL %s_results: got %0d %0d %0d %0d, required %0d %0d %0d %0d", name,
               r_X, r_Y, r_Z, r_T, ex, ey, ez, et);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || mul_bus.mul_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: busy=%b done=%b req=%b, required 0 0 0", busy, done,
               mul_bus.mul_req);
    end
    tests++;
    if (mul_bus.mul_a !== '0 || mul_bus.mul_b !== '0) begin
      fails++;
      $display("FAIL reset_ops: a=%0d b=%0d, required 0 0", mul_bus.mul_a, mul_bus.mul_b);
    end
    check_res("reset", '0, '0, '0, '0);
    rst = 1'b0;
  endtask

  task automatic test_p3;
    int dc, g; bit st; logic [31:0] rh;
    run_conv(1'b1, 2, 3, 5, 7, 0, 0, 1'b0, dc, g, st, rh);
    tests++;
    if (dc !== DONE_P3) begin
      fails++; $display("FAIL p3_done_cycle: got %0d, required %0d", dc, DONE_P3);
    end
    tests++;
    if (g !== 4) begin fails++; $display("FAIL p3_grants: got %0d, required 4", g); end
    tests++;
    if (rh !== REQ_P3) begin
      fails++; $display("FAIL p3_req_cycles: got %h, required %h", rh, REQ_P3);
    end
    check_res("p3", 14, 15, 35, 6);
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL p3_pulse: done=%b busy=%b after done, required 0 0", done, busy);
    end
  endtask

  task automatic test_p2;
    int dc, g; bit st; logic [31:0] rh;
    run_conv(1'b0, 2, 3, 5, 7, 0, 0, 1'b0, dc, g, st, rh);
    tests++;
    if (dc !== DONE_P2) begin
      fails++; $display("FAIL p2_done_cycle: got %0d, required %0d", dc, DONE_P2);
    end
    tests++;
    if (g !== 3) begin fails++; $display("FAIL p2_grants: got %0d, required 3", g); end
    check_res("p2", 14, 15, 35, 0);
  endtask

  task automatic test_stall;
    int dc, g; bit st; logic [31:0] rh;
    run_conv(1'b1, 2, 3, 5, 7, STALL_FROM, 4, 1'b0, dc, g, st, rh);
    tests++;
    if (dc !== DONE_STALL) begin
      fails++; $display("FAIL stall_done_cycle: got %0d, required %0d", dc, DONE_STALL);
    end
    tests++;
    if (st !== 1'b1) begin
      fails++; $display("FAIL stall_operands: stable=%b, required 1", st);
    end
    check_res("stall", 14, 15, 35, 6);
  endtask

  task automatic test_ignore;
    int dc, g; bit st; logic [31:0] rh;
    run_conv(1'b1, 2, 3, 5, 7, 0, 0, 1'b1, dc, g, st, rh);
    tests++;
    if (dc !== DONE_P3) begin
      fails++; $display("FAIL ignore_done_cycle: got %0d, required %0d", dc, DONE_P3);
    end
    check_res("ignore", 14, 15, 35, 6);
  endtask

  task automatic test_reset_mid;
    int dc, g; bit st; logic [31:0] rh;
    bit seen_done;
    @(posedge clk); #1;
    p_X = 3; p_Y = 4; p_Z = 5; p_T = 6; mode = 1'b1; start = 1'b1;
    for (int n = 1; n <= RST_CYC; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || mul_bus.mul_req !== 1'b0 ||
        mul_bus.mul_a !== '0 || mul_bus.mul_b !== '0) begin
      fails++;
      $display("FAIL rstmid_outputs: busy=%b done=%b req=%b a=%0d b=%0d, required all 0",
               busy, done, mul_bus.mul_req, mul_bus.mul_a, mul_bus.mul_b);
    end
    check_res("rstmid", '0, '0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    tests++;
    if (seen_done) begin
      fails++; $display("FAIL rstmid_idle: done/busy seen after reset, required none");
    end
    check_res("rstmid_late", '0, '0, '0, '0);
    run_conv(1'b1, 2, 3, 5, 7, 0, 0, 1'b0, dc, g, st, rh);
    tests++;
    if (dc !== DONE_P3) begin
      fails++; $display("FAIL rstmid_rerun_cycle: got %0d, required %0d", dc, DONE_P3);
    end
    check_res("rstmid_rerun", 14, 15, 35, 6);
  endtask

  task automatic test_back_to_back;
    int dc, g; bit st; logic [31:0] rh;
    run_conv(1'b0, 2, 3, 5, 7, 0, 0, 1'b0, dc, g, st, rh);
    check_res("b2b_first", 14, 15, 35, 0);
    run_conv(1'b1, 3, 4, 5, 6, 0, 0, 1'b0, dc, g, st, rh);
    tests++;
    if (dc !== DONE_P3) begin
      fails++; $display("FAIL b2b_done_cycle: got %0d, required %0d", dc, DONE_P3);
    end
    check_res("b2b_second", 18, 20, 30, 12);
  endtask

  initial begin
    test_reset();
    test_p3();
    test_p2();
    test_stall();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
